// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner/debouncer.
package keypad_pkg;

  localparam int KEY_W    = 4;
  localparam int LINES    = 4;
  localparam int NUM_KEYS = LINES * LINES;

  typedef struct packed {
    logic             press;
    logic [KEY_W-1:0] code;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  function automatic logic is_onehot4(input logic [LINES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [LINES-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < LINES; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Synchronous show-ahead FIFO; the head entry is always presented on head_data.
module keypad_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full, empty, pop_ok, push_ok;

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    drop     = push && full && !pop_ok;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q[AW-1:0]];
  assign valid     = !empty;

endmodule

// File: rtl/keypad_debounce.sv
// Row-scanned 4x4 keypad debouncer: one sample per stable row dwell, per-key
// agreement counters, and press/release events queued in a show-ahead FIFO.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int DB_SCANS   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_sel,
  input  logic [3:0]  col_raw,
  output logic [15:0] matrix,
  output logic        evt_valid,
  output logic        evt_press,
  output logic [3:0]  evt_code,
  input  logic        evt_ready,
  output logic        overflow
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] SETTLE_PRE = CNT_W'(SETTLE_CYC - 1);
  localparam logic [3:0]       DB_LAST    = 4'(DB_SCANS - 1);

  logic [3:0]          col_s1_q, col_s1_d, col_s2_q, col_s2_d;
  logic [3:0]          row_q, row_d;
  logic [CNT_W-1:0]    settle_q, settle_d;
  logic [15:0]         matrix_q, matrix_d;
  logic [15:0][3:0]    key_cnt_q, key_cnt_d;
  logic [3:0]          pend_q, pend_d;
  logic [1:0]          pend_row_q, pend_row_d;
  logic                ovf_q, ovf_d;

  logic                row_stable, sample, push, pop, drop;
  logic [1:0]          row_idx, sel;
  evt_t                push_evt, head_evt;

  always_comb begin
    col_s1_d   = col_raw;
    col_s2_d   = col_s1_q;
    row_d      = row_sel;
    row_idx    = onehot_idx(row_q);
    row_stable = (row_sel == row_q) && is_onehot4(row_sel);
    settle_d   = '0;
    if (row_stable) settle_d = (settle_q == SETTLE_MAX) ? settle_q : settle_q + 1'b1;
    sample     = row_stable && (settle_q == SETTLE_PRE);

    matrix_d   = matrix_q;
    key_cnt_d  = key_cnt_q;
    pend_d     = pend_q;
    pend_row_d = pend_row_q;
    push       = 1'b0;
    push_evt   = '0;
    sel        = 2'd0;

    // Drain the lowest pending column first; matrix_q already holds the new state.
    for (int c = LINES - 1; c >= 0; c--) begin
      if (pend_q[c]) sel = 2'(c);
    end
    if (pend_q != '0) begin
      push           = 1'b1;
      push_evt.press = matrix_q[{pend_row_q, sel}];
      push_evt.code  = {pend_row_q, sel};
      pend_d[sel]    = 1'b0;
    end

    if (sample) begin
      for (int c = 0; c < LINES; c++) begin
        if (col_s2_q[c] != matrix_q[{row_idx, 2'(c)}]) begin
          if (key_cnt_q[{row_idx, 2'(c)}] == DB_LAST) begin
            matrix_d[{row_idx, 2'(c)}]  = ~matrix_q[{row_idx, 2'(c)}];
            key_cnt_d[{row_idx, 2'(c)}] = 4'd0;
            pend_d[c]                   = 1'b1;
            pend_row_d                  = row_idx;
          end else begin
            key_cnt_d[{row_idx, 2'(c)}] = key_cnt_q[{row_idx, 2'(c)}] + 4'd1;
          end
        end else begin
          key_cnt_d[{row_idx, 2'(c)}] = 4'd0;
        end
      end
    end

    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_s1_q   <= '0;
      col_s2_q   <= '0;
      row_q      <= '0;
      settle_q   <= '0;
      matrix_q   <= '0;
      key_cnt_q  <= '0;
      pend_q     <= '0;
      pend_row_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      col_s1_q   <= col_s1_d;
      col_s2_q   <= col_s2_d;
      row_q      <= row_d;
      settle_q   <= settle_d;
      matrix_q   <= matrix_d;
      key_cnt_q  <= key_cnt_d;
      pend_q     <= pend_d;
      pend_row_q <= pend_row_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pop = evt_valid && evt_ready;

  keypad_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_evt),
    .pop       (pop),
    .head_data (head_evt),
    .valid     (evt_valid),
    .drop      (drop)
  );

  assign matrix    = matrix_q;
  assign evt_press = head_evt.press;
  assign evt_code  = head_evt.code;
  assign overflow  = ovf_q;

endmodule

// File: doc/keypad_debounce.md
KEYPAD_DEBOUNCE -- requirements
Module: keypad_debounce

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16, meaning cycles row_sel must be stable before a sample; legal values 8 and above.
REQ-002 SHALL have parameter DB_SCANS, default 4, meaning consecutive disagreeing samples needed to flip a key's state; legal range 1..15.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning event FIFO entries; power of 2, 4 or more.
REQ-004 SHALL have port clk, input, width 1, the single clock.
REQ-005 SHALL have port rst_n, input, width 1; reset is asynchronous and active-low.
REQ-006 SHALL have port row_sel, input, width 4, one-hot row strobe from the scan driver; bit r selects row r.
REQ-007 SHALL have port col_raw, input, width 4, asynchronous column lines; bit c is high when key (r,c) is pressed.
REQ-008 SHALL have port matrix, output, width 16, the debounced key state; bit r*4+c is key (r,c).
REQ-009 SHALL have port evt_valid, output, width 1, high when an event is at the FIFO head.
REQ-010 SHALL have port evt_press, output, width 1; 1 means press, 0 means release.
REQ-011 SHALL have port evt_code, output, width 4, key index r*4+c.
REQ-012 SHALL have port evt_ready, input, width 1, consumer accept.
REQ-013 SHALL have port overflow, output, width 1, sticky flag set when an event is dropped.

Function
REQ-014 SHALL pass col_raw through a 2-flop synchronizer before any use.
REQ-015 SHALL register row_sel every cycle and reset the settle counter to 0 whenever row_sel differs from its registered value or is not one-hot.
REQ-016 SHALL take exactly one sample per row dwell, in the cycle the settle counter reaches SETTLE_CYC; the counter then saturates, so there is no resample until row_sel changes.
REQ-017 SHALL, per key, increment a counter when the sampled bit differs from the matrix bit and clear it when they are equal; keys of other rows are untouched.
REQ-018 SHALL, when a key counter reaches DB_SCANS, toggle that matrix bit in the cycle after the sample, clear the counter, and set the key's bit in a 4-bit pending mask.
REQ-019 SHALL serialize the pending mask one key per cycle in ascending column order, pushing {press = new matrix bit, code} into the FIFO.
REQ-020 SHALL make a pushed event visible on evt_valid/evt_press/evt_code the cycle after its write; outputs are show-ahead and held stable while evt_valid=1 and evt_ready=0.
REQ-021 SHALL pop the FIFO head on a cycle with evt_valid=1 and evt_ready=1; a simultaneous push and pop when full SHALL succeed without loss.
REQ-022 SHALL, on a push into a full FIFO without a same-cycle pop, drop the new event and set overflow; matrix SHALL still update.
REQ-023 SHALL keep overflow high until reset.
REQ-024 SHALL produce a given row's pending events in FIFO order; SETTLE_CYC of 8 or more guarantees draining finishes before the next sample.
REQ-025 SHALL ignore col_raw while row_sel is zero or multi-hot.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear matrix, all key counters, the pending mask, the settle counter, the synchronizer flops, FIFO pointers, evt_valid and overflow.
REQ-027 SHALL discard in-flight events when reset is asserted mid-operation; the first sample after release uses a full SETTLE_CYC dwell.

Structure
REQ-028 SHALL place the key-index width (4), the row/column count (4) and the event record type {press, code} in shared package keypad_pkg.
REQ-029 SHALL implement the event queue as sub-module keypad_evt_fifo, a synchronous show-ahead FIFO parameterised by depth and record width.

Verification
REQ-030 SHALL cover a single press: row_sel=0001 stable, col_raw=0010 held for 4 dwells -> matrix[1]=1 after the 4th sample, one event {press=1, code=1}, no others.
REQ-031 SHALL cover a bounce: col_raw toggling every dwell on row 2 col 0 -> matrix[8] stays 0 and no event is produced.
REQ-032 SHALL cover a multi-key row: row 3 with col_raw=1111 held for 4 dwells -> codes 12, 13, 14, 15 in order, all press=1, on consecutive cycles with evt_ready=1.
REQ-033 SHALL cover backpressure and overflow: evt_ready=0, 9 debounced changes with depth 8 -> 8 events retained, overflow=1; matrix reflects all 9 changes.
REQ-034 SHALL cover a glitch: row_sel=0110 for 100 cycles -> no sample taken and no counter change.
REQ-035 SHALL cover reset mid-operation: rst_n pulsed low with 3 events queued -> evt_valid=0, matrix=0, overflow=0 immediately; normal operation resumes afterwards.
